sonar_tof_meter: RTL

Time-of-flight measurement stage downstream of the SonarOnChip detection datapath.
- Fires a transmit burst on `tx_out`.
- Waits a blanking interval to mask direct coupling.
- Listens on the datapath comparator output `cmp`, sampled on `ce_pcm`, and debounces it.
- Reports the echo delay in `ce_pcm` ticks, or flags a timeout.
- Sits between the per-channel `cmp` output and the Wishbone register/IRQ logic.

---
 rtl/sonar_tof_meter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/sonar_tof_meter.sv
`default_nettype none
// ============================================================================
// sonar_tof_meter : transmit burst, blanking, debounced echo listen, ToF result
// Revision 1.0
// ============================================================================
module sonar_tof_meter #(
  parameter int CNT_W        = 16,
  parameter int DEB          = 3,
  parameter int BURST_CYCLES = 8,
  parameter int HALF_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_pcm,
  input  logic              start,
  input  logic              abort,
  input  logic              cmp,
  input  logic [HALF_W-1:0] tx_half,
  input  logic [CNT_W-1:0]  blank_len,
  input  logic [CNT_W-1:0]  timeout_len,
  output logic              tx_out,
  output logic              busy,
  output logic              valid,
  output logic [CNT_W-1:0]  tof,
  output logic              timeout
);

  localparam int                c_NH_W      = $clog2(2 * BURST_CYCLES + 1);
  localparam logic [c_NH_W-1:0] c_LAST_HALF = c_NH_W'(2 * BURST_CYCLES - 1);
  localparam logic [3:0]        c_DEB       = 4'(DEB);
  localparam logic [CNT_W-1:0]  c_CNT_MAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BURST  = 3'd1,
    S_BLANK  = 3'd2,
    S_LISTEN = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_hit_tick;
  logic [CNT_W-1:0]  r_tof;
  logic [3:0]        r_deb;
  logic [HALF_W-1:0] r_tx_half;
  logic [HALF_W-1:0] r_half_cnt;
  logic [c_NH_W-1:0] r_nhalf;
  logic              r_tx_out;
  logic              r_busy;
  logic              r_valid;
  logic              r_timeout;

  logic [CNT_W-1:0]  w_cnt_inc;
  logic [CNT_W-1:0]  w_hit_val;
  logic [3:0]        w_deb_inc;
  logic              w_run;
  logic              w_accept;
  logic              w_half_end;
  logic              w_burst_end;
  logic              w_echo;
  logic              w_tout;
  logic              w_blank_done;

  assign w_run        = (r_state == S_BURST) || (r_state == S_BLANK) || (r_state == S_LISTEN);
  assign w_accept     = ((r_state == S_IDLE) || (r_state == S_DONE)) && start && !abort;
  assign w_cnt_inc    = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_deb_inc    = r_deb + 4'd1;
  // The first high sample of a run captures the tick it occurred on.
  assign w_hit_val    = (r_deb == 4'd0) ? w_cnt_inc : r_hit_tick;
  assign w_half_end   = (r_half_cnt == r_tx_half);
  assign w_burst_end  = (r_state == S_BURST) && w_half_end && (r_nhalf == c_LAST_HALF);
  assign w_echo       = (r_state == S_LISTEN) && ce_pcm && cmp && (w_deb_inc == c_DEB);
  // An echo qualifying on the same sample takes precedence over the timeout.
  assign w_tout       = ((r_state == S_BLANK) || (r_state == S_LISTEN)) && ce_pcm &&
                        (w_cnt_inc >= timeout_len) && !w_echo;
  assign w_blank_done = (r_state == S_BLANK) && ce_pcm && (w_cnt_inc >= blank_len);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) w_state_nxt = S_BURST;
      end
      S_BURST: begin
        if (abort)            w_state_nxt = S_IDLE;
        else if (w_burst_end) w_state_nxt = S_BLANK;
      end
      S_BLANK: begin
        if (abort)             w_state_nxt = S_IDLE;
        else if (w_tout)       w_state_nxt = S_DONE;
        else if (w_blank_done) w_state_nxt = S_LISTEN;
      end
      S_LISTEN: begin
        if (abort)                 w_state_nxt = S_IDLE;
        else if (w_echo || w_tout) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == S_BURST) || (w_state_nxt == S_BLANK) ||
                 (w_state_nxt == S_LISTEN);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_hit_tick <= '0;
      r_tof      <= '0;
      r_deb      <= '0;
      r_tx_half  <= '0;
      r_half_cnt <= '0;
      r_nhalf    <= '0;
      r_tx_out   <= 1'b0;
      r_valid    <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_accept) begin
        // A ce_pcm on the accepting clock is already the first tick.
        r_cnt      <= ce_pcm ? CNT_W'(1) : '0;
        r_timeout  <= 1'b0;
        r_deb      <= '0;
        r_half_cnt <= '0;
        r_nhalf    <= '0;
        r_tx_half  <= tx_half;
        r_tx_out   <= 1'b1;
      end else if (w_run) begin
        if (ce_pcm) r_cnt <= w_cnt_inc;
        if (abort) begin
          r_tx_out <= 1'b0;
        end else begin
          case (r_state)
            S_BURST: begin
              if (w_half_end) begin
                r_half_cnt <= '0;
                r_nhalf    <= r_nhalf + c_NH_W'(1);
                r_tx_out   <= w_burst_end ? 1'b0 : ~r_tx_out;
              end else begin
                r_half_cnt <= r_half_cnt + HALF_W'(1);
              end
            end
            S_LISTEN: begin
              if (ce_pcm) begin
                if (cmp) begin
                  r_deb      <= w_deb_inc;
                  r_hit_tick <= w_hit_val;
                end else begin
                  r_deb <= '0;
                end
              end
            end
            default: ;
          endcase
          if (w_echo) begin
            r_tof     <= w_hit_val;
            r_timeout <= 1'b0;
            r_valid   <= 1'b1;
          end else if (w_tout) begin
            r_tof     <= timeout_len;
            r_timeout <= 1'b1;
            r_valid   <= 1'b1;
          end
        end
      end
    end
  end

  assign tx_out  = r_tx_out;
  assign busy    = r_busy;
  assign valid   = r_valid;
  assign tof     = r_tof;
  assign timeout = r_timeout;

endmodule
`default_nettype wire
